w_level_q: RTL and testbench
============================

Name: w_level_q

Overview:
- Parametrised write-back stage for the pipelined MIPS core.
- Captures completed M-stage results and forms the final register-file write data, including load byte/half extraction and extension.
- Buffers pending writes in a DEPTH-entry queue, because the GRF write port is shared with the CP0/exception path and may be withheld for some cycles.
- Provides a youngest-first forwarding lookup over all queued writes.

Parameters:
- XLEN, 32, datapath width (≥16, multiple of 8).
- DEPTH, 4, write-queue entries (power of 2, ≥2).
- PC_OFS, 8, link offset added to PC for GRFWD_pc8.

Ports:
- Clk  in  1  clock, rising edge.
- Rst  in  1  asynchronous active-low reset.
- Flush  in  1  synchronous queue/register clear (Reg_Rst equivalent).
- In_Valid  in  1  M-stage result valid.
- In_Ready  out  1  queue can accept; equals !full.
- In_A3  in  5  destination register.
- In_WDSel  in  2  0=alu(Y), 1=dm(DR), 2=pc+PC_OFS, 3=HILO.
- In_Ext  in  3  0=word, 1=lb, 2=lbu, 3=lh, 4=lhu.
- In_AddrLo  in  2  load byte offset.
- In_PC  in  XLEN  instruction PC.
- In_Y  in  XLEN  ALU result.
- In_DR  in  XLEN  raw DM word.
- In_HILO  in  XLEN  mf result.
- RF_Gnt  in  1  GRF write port granted this cycle.
- RF_We  out  1  GRF write enable.
- RF_A3  out  5  GRF write address.
- RF_WD  out  XLEN  GRF write data.
- Fwd_RA  in  5  forwarding lookup address.
- Fwd_Hit  out  1  a queued entry writes Fwd_RA.
- Fwd_Data  out  XLEN  data of the youngest matching entry.
- Count  out  clog2(DEPTH)+1  occupancy.

Behaviour:
- Reset (Rst=0, asynchronous): head=tail=0, Count=0, all entry valid bits 0. Outputs: RF_We=0, Fwd_Hit=0, In_Ready=1. RF_A3 and RF_WD read 0 because head-slot contents are gated by valid.
- Enqueue occurs on the rising edge when In_Valid & In_Ready & In_A3≠0.
  - In_A3=0 is accepted but discarded (no entry written, Count unchanged).
- Write-data formation happens at enqueue; entries store the final WD, not the raw fields.
  - WDSel 0 → In_Y.
  - WDSel 1 → DR: word returns DR. Byte selects DR[8*AddrLo+7 -: 8]. Half selects DR[16*AddrLo[1]+15 -: 16]. lb/lh sign-extend to XLEN; lbu/lhu zero-extend. In_AddrLo[0] is ignored for halfwords.
  - WDSel 2 → In_PC + PC_OFS, modulo 2^XLEN.
  - WDSel 3 → In_HILO.
  - In_Ext values 5–7 behave as word.
- Drain:
  - RF_We = head-entry valid; RF_A3 and RF_WD come from the head entry, combinationally from registered state.
  - The head pops on the rising edge where RF_We & RF_Gnt.
- Latency: an accepted result is visible on RF_We at the earliest 1 cycle after acceptance, and written on the same edge RF_Gnt is seen.
- Full (Count=DEPTH): In_Ready=0 and In_Valid is ignored.
  - A simultaneous pop does not open a slot in the same cycle; In_Ready is registered-state based.
- Empty with enqueue and RF_Gnt in the same cycle: the new entry is not written that cycle (no bypass).
- Simultaneous enqueue and pop when not full: both happen and Count is unchanged.
- Pointer wrap: head and tail are clog2(DEPTH)-bit counters that wrap from DEPTH-1 to 0. Full/empty are derived from Count.
- Forwarding is combinational:
  - Scan valid entries youngest (tail-1) to oldest (head); the first with A3==Fwd_RA gives Fwd_Hit=1 and Fwd_Data.
  - Fwd_RA=0 always yields Fwd_Hit=0 and Fwd_Data=0; no hit also yields Fwd_Data=0.
  - Forwarding does not see the entry being enqueued in the same cycle.
- Flush:
  - Synchronous; clears all valid bits, head, tail and Count on the next edge.
  - Overrides an enqueue and a pop in the same cycle; the GRF write of the current head still occurs if RF_Gnt is 1 on that edge.
- Rst asserted mid-drain: the queue empties immediately and no further RF_We is asserted until new data is enqueued.

Test Plan:
- Reset then idle → RF_We=0, In_Ready=1, Count=0, Fwd_Hit=0.
- lb from DR=0x12345680, AddrLo=0, A3=5, RF_Gnt=1 → next cycle RF_We=1, A3=5, WD=0xFFFFFF80; lbu at AddrLo=3 → WD=0x00000012; lh at AddrLo=2 → WD=0x00001234.
- jal: WDSel=2, PC=0x00003000, A3=31 → WD=0x00003008. A3=0 input → Count stays 0 and no RF_We.
- RF_Gnt=0; enqueue (A3=8,WD=1), (A3=9,WD=2), (A3=8,WD=3), (A3=10,WD=4) → Count=4 and In_Ready=0; Fwd_RA=8 → Hit=1, Data=3. A fifth In_Valid is dropped.
- From full, raise RF_Gnt for 4 cycles while enqueuing every cycle the queue is not full → writes appear in order 8/1, 9/2, 8/3, 10/4 and pointers wrap; the simultaneous enqueue/pop keeps Count constant.
- Fill 3 entries, assert Flush together with In_Valid → next cycle Count=0 and Fwd_Hit=0. Assert Rst low asynchronously mid-cycle with 2 entries → RF_We drops to 0 immediately.

Source files
------------

// File: rtl/w_level_q_if.sv
`default_nettype none
// ============================================================================
// Module      : w_level_q_if
// Description : M-stage result, GRF write port and forwarding lookup bundle
//               for the write-back queue.
// Revision    : 1.0 - initial release
// ============================================================================
interface w_level_q_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [4:0]      in_a3;
    logic [1:0]      in_wdsel;
    logic [2:0]      in_ext;
    logic [1:0]      in_addrlo;
    logic [XLEN-1:0] in_pc;
    logic [XLEN-1:0] in_y;
    logic [XLEN-1:0] in_dr;
    logic [XLEN-1:0] in_hilo;
    logic            rf_gnt;
    logic            rf_we;
    logic [4:0]      rf_a3;
    logic [XLEN-1:0] rf_wd;
    logic [4:0]      fwd_ra;
    logic            fwd_hit;
    logic [XLEN-1:0] fwd_data;

    modport master (
        output in_valid, in_a3, in_wdsel, in_ext, in_addrlo,
        output in_pc, in_y, in_dr, in_hilo, rf_gnt, fwd_ra,
        input  in_ready, rf_we, rf_a3, rf_wd, fwd_hit, fwd_data
    );

    modport slave (
        input  in_valid, in_a3, in_wdsel, in_ext, in_addrlo,
        input  in_pc, in_y, in_dr, in_hilo, rf_gnt, fwd_ra,
        output in_ready, rf_we, rf_a3, rf_wd, fwd_hit, fwd_data
    );
endinterface
`default_nettype wire

// File: rtl/w_level_q.sv
`default_nettype none
// ============================================================================
// Module      : w_level_q
// Description : Write-back stage: forms final GRF write data and buffers it in
//               a DEPTH-entry queue with youngest-first forwarding lookup.
// Revision    : 1.0 - initial release
// ============================================================================
module w_level_q #(
    parameter int XLEN   = 32,
    parameter int DEPTH  = 4,
    parameter int PC_OFS = 8
) (
    input  wire logic                     clk,
    input  wire logic                     rst_n,
    input  wire logic                     i_flush,
    w_level_q_if.slave                    bus,
    output logic [$clog2(DEPTH):0]        o_count
);
    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    localparam logic [1:0] c_SEL_ALU  = 2'd0;
    localparam logic [1:0] c_SEL_DM   = 2'd1;
    localparam logic [1:0] c_SEL_PC   = 2'd2;
    localparam logic [2:0] c_EXT_LB   = 3'd1;
    localparam logic [2:0] c_EXT_LBU  = 3'd2;
    localparam logic [2:0] c_EXT_LH   = 3'd3;
    localparam logic [2:0] c_EXT_LHU  = 3'd4;

    logic [c_PTR_W-1:0] r_head;
    logic [c_PTR_W-1:0] r_tail;
    logic [c_CNT_W-1:0] r_count;
    logic [DEPTH-1:0]   r_valid;
    logic [4:0]         r_a3 [DEPTH];
    logic [XLEN-1:0]    r_wd [DEPTH];

    logic               w_full;
    logic               w_push;
    logic               w_pop;
    logic [7:0]         w_byte;
    logic [15:0]        w_half;
    logic [XLEN-1:0]    w_load;
    logic [XLEN-1:0]    w_wd;
    logic [c_PTR_W-1:0] w_idx;
    logic               w_fwd_hit;
    logic [XLEN-1:0]    w_fwd_data;

    assign w_full       = (r_count == c_CNT_W'(DEPTH));
    assign bus.in_ready = !w_full;
    // Writes to $0 are accepted from the pipeline but never occupy a slot.
    assign w_push  = bus.in_valid && !w_full && (bus.in_a3 != 5'd0) && !i_flush;
    assign w_pop   = r_valid[r_head] && bus.rf_gnt && !i_flush;
    assign o_count = r_count;

    always_comb begin
        w_byte = bus.in_dr[{bus.in_addrlo, 3'b000} +: 8];
        w_half = bus.in_dr[{bus.in_addrlo[1], 4'b0000} +: 16];
        case (bus.in_ext)
            c_EXT_LB:  w_load = {{(XLEN-8){w_byte[7]}}, w_byte};
            c_EXT_LBU: w_load = {{(XLEN-8){1'b0}}, w_byte};
            c_EXT_LH:  w_load = {{(XLEN-16){w_half[15]}}, w_half};
            c_EXT_LHU: w_load = {{(XLEN-16){1'b0}}, w_half};
            default:   w_load = bus.in_dr;
        endcase
    end

    always_comb begin
        case (bus.in_wdsel)
            c_SEL_ALU: w_wd = bus.in_y;
            c_SEL_DM:  w_wd = w_load;
            c_SEL_PC:  w_wd = bus.in_pc + XLEN'(PC_OFS);
            default:   w_wd = bus.in_hilo;
        endcase
    end

    assign bus.rf_we = r_valid[r_head];
    assign bus.rf_a3 = r_valid[r_head] ? r_a3[r_head] : 5'd0;
    assign bus.rf_wd = r_valid[r_head] ? r_wd[r_head] : '0;

    // Walk oldest to youngest so the last match (the youngest) wins.
    always_comb begin
        w_idx      = r_head;
        w_fwd_hit  = 1'b0;
        w_fwd_data = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_idx = r_head + c_PTR_W'(k);
            if (r_valid[w_idx] && (r_a3[w_idx] == bus.fwd_ra) && (bus.fwd_ra != 5'd0)) begin
                w_fwd_hit  = 1'b1;
                w_fwd_data = r_wd[w_idx];
            end
        end
    end

    assign bus.fwd_hit  = w_fwd_hit;
    assign bus.fwd_data = w_fwd_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_valid <= '0;
        end else if (i_flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_valid <= '0;
        end else begin
            if (w_push) begin
                r_valid[r_tail] <= 1'b1;
                r_tail          <= r_tail + 1'b1;
            end
            if (w_pop) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= r_head + 1'b1;
            end
            r_count <= r_count + c_CNT_W'(w_push) - c_CNT_W'(w_pop);
        end
    end

    // Payload needs no reset: it is only observed through the valid bits.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_a3[r_tail] <= bus.in_a3;
            r_wd[r_tail] <= w_wd;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_w_level_q.sv
`default_nettype none
// ============================================================================
// Module      : tb_w_level_q
// Description : Directed self-checking bench for the write-back queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_w_level_q;
    logic       clk;
    logic       rst_n;
    logic       i_flush;
    logic [2:0] o_count;
    int         n_assert;
    int         n_fail;

    w_level_q_if #(.XLEN(32)) bus ();

    w_level_q #(.XLEN(32), .DEPTH(4), .PC_OFS(8)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_flush (i_flush),
        .bus     (bus),
        .o_count (o_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [4:0] a3, input logic [1:0] sel,
                         input logic [2:0] ext, input logic [1:0] lo, input logic [31:0] pc,
                         input logic [31:0] y, input logic [31:0] dr, input logic [31:0] hilo);
        bus.in_valid  = v;
        bus.in_a3     = a3;
        bus.in_wdsel  = sel;
        bus.in_ext    = ext;
        bus.in_addrlo = lo;
        bus.in_pc     = pc;
        bus.in_y      = y;
        bus.in_dr     = dr;
        bus.in_hilo   = hilo;
    endtask

    initial begin
        logic [4:0]  ea [4];
        logic [31:0] ew [4];
        ea = '{5'd8, 5'd9, 5'd8, 5'd10};
        ew = '{32'd1, 32'd2, 32'd3, 32'd4};
        n_assert = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        i_flush  = 1'b0;
        bus.rf_gnt = 1'b0;
        bus.fwd_ra = 5'd5;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #12 rst_n = 1'b1;
        tick();
        check("rst_we", 32'(bus.rf_we), 32'd0);
        check("rst_ready", 32'(bus.in_ready), 32'd1);
        check("rst_count", 32'(o_count), 32'd0);
        check("rst_hit", 32'(bus.fwd_hit), 32'd0);
        check("rst_a3", 32'(bus.rf_a3), 32'd0);
        check("rst_wd", bus.rf_wd, 32'd0);

        // Load extraction and link address, drained one per cycle.
        bus.rf_gnt = 1'b1;
        drive(1, 5, 1, 1, 0, 0, 0, 32'h12345680, 0);
        tick();
        drive(1, 6, 1, 2, 3, 0, 0, 32'h12345680, 0);
        #1;
        check("lb_we", 32'(bus.rf_we), 32'd1);
        check("lb_a3", 32'(bus.rf_a3), 32'd5);
        check("lb_wd", bus.rf_wd, 32'hFFFFFF80);
        check("lb_count", 32'(o_count), 32'd1);
        check("lb_fwd_hit", 32'(bus.fwd_hit), 32'd1);
        check("lb_fwd_data", bus.fwd_data, 32'hFFFFFF80);
        tick();
        drive(1, 7, 1, 3, 2, 0, 0, 32'h12345680, 0);
        #1;
        check("lbu_a3", 32'(bus.rf_a3), 32'd6);
        check("lbu_wd", bus.rf_wd, 32'h00000012);
        check("lbu_count", 32'(o_count), 32'd1);
        tick();
        drive(1, 31, 2, 0, 0, 32'h00003000, 0, 0, 0);
        #1;
        check("lh_a3", 32'(bus.rf_a3), 32'd7);
        check("lh_wd", bus.rf_wd, 32'h00001234);
        tick();
        drive(1, 0, 0, 0, 0, 0, 32'hDEAD, 0, 0);
        #1;
        check("jal_a3", 32'(bus.rf_a3), 32'd31);
        check("jal_wd", bus.rf_wd, 32'h00003008);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        check("a3zero_count", 32'(o_count), 32'd0);
        check("a3zero_we", 32'(bus.rf_we), 32'd0);

        // Fill with the port withheld, using every data source.
        bus.rf_gnt = 1'b0;
        drive(1, 8, 0, 0, 0, 0, 32'd1, 0, 0);          tick();
        drive(1, 9, 3, 0, 0, 0, 0, 0, 32'd2);          tick();
        drive(1, 8, 1, 0, 0, 0, 0, 32'd3, 0);          tick();
        drive(1, 10, 1, 7, 0, 0, 0, 32'd4, 0);         tick();
        drive(1, 11, 0, 0, 0, 0, 32'd99, 0, 0);
        bus.fwd_ra = 5'd8;
        #1;
        check("full_count", 32'(o_count), 32'd4);
        check("full_ready", 32'(bus.in_ready), 32'd0);
        check("full_fwd8_hit", 32'(bus.fwd_hit), 32'd1);
        check("full_fwd8_data", bus.fwd_data, 32'd3);
        bus.fwd_ra = 5'd9;
        #1;
        check("full_fwd9_data", bus.fwd_data, 32'd2);
        bus.fwd_ra = 5'd0;
        #1;
        check("fwd0_hit", 32'(bus.fwd_hit), 32'd0);
        check("fwd0_data", bus.fwd_data, 32'd0);
        bus.fwd_ra = 5'd12;
        #1;
        check("fwd_miss_hit", 32'(bus.fwd_hit), 32'd0);
        check("fwd_miss_data", bus.fwd_data, 32'd0);
        tick();
        check("drop_count", 32'(o_count), 32'd4);
        check("drop_head_a3", 32'(bus.rf_a3), 32'd8);
        check("drop_head_wd", bus.rf_wd, 32'd1);

        // Drain from full while refilling whenever there is room.
        bus.rf_gnt = 1'b1;
        for (int k = 0; k < 4; k++) begin
            drive(1, 5'(11 + k), 0, 0, 0, 0, 32'(5 + k), 0, 0);
            #1;
            check("drain_a3", 32'(bus.rf_a3), 32'(ea[k]));
            check("drain_wd", bus.rf_wd, ew[k]);
            check("drain_ready", 32'(bus.in_ready), (k == 0) ? 32'd0 : 32'd1);
            tick();
            check("drain_count", 32'(o_count), 32'd3);
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        bus.fwd_ra = 5'd13;
        #1;
        check("wrap_fwd_hit", 32'(bus.fwd_hit), 32'd1);
        check("wrap_fwd_data", bus.fwd_data, 32'd7);
        for (int k = 0; k < 3; k++) begin
            check("wrap_a3", 32'(bus.rf_a3), 32'(12 + k));
            check("wrap_wd", bus.rf_wd, 32'(6 + k));
            tick();
        end
        check("wrap_empty_count", 32'(o_count), 32'd0);
        check("wrap_empty_we", 32'(bus.rf_we), 32'd0);

        // Flush overrides a concurrent enqueue and pop.
        bus.rf_gnt = 1'b0;
        drive(1, 15, 0, 0, 0, 0, 32'd9, 0, 0);         tick();
        drive(1, 16, 0, 0, 0, 0, 32'd10, 0, 0);        tick();
        drive(1, 17, 0, 0, 0, 0, 32'd11, 0, 0);        tick();
        drive(1, 18, 0, 0, 0, 0, 32'd12, 0, 0);
        i_flush    = 1'b1;
        bus.rf_gnt = 1'b1;
        #1;
        check("flush_pre_count", 32'(o_count), 32'd3);
        check("flush_pre_a3", 32'(bus.rf_a3), 32'd15);
        tick();
        i_flush = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        bus.fwd_ra = 5'd18;
        #1;
        check("flush_count", 32'(o_count), 32'd0);
        check("flush_we", 32'(bus.rf_we), 32'd0);
        check("flush_hit", 32'(bus.fwd_hit), 32'd0);

        // Enqueue into an empty queue while granted: no bypass.
        drive(1, 20, 0, 0, 0, 0, 32'h21, 0, 0);
        bus.fwd_ra = 5'd20;
        #1;
        check("nobyp_we", 32'(bus.rf_we), 32'd0);
        check("nobyp_hit", 32'(bus.fwd_hit), 32'd0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        check("nobyp_next_we", 32'(bus.rf_we), 32'd1);
        check("nobyp_next_a3", 32'(bus.rf_a3), 32'd20);
        check("nobyp_next_wd", bus.rf_wd, 32'h21);
        tick();
        check("nobyp_popped", 32'(o_count), 32'd0);

        // Asynchronous reset in the middle of a cycle with work pending.
        bus.rf_gnt = 1'b0;
        drive(1, 21, 0, 0, 0, 0, 32'h30, 0, 0);        tick();
        drive(1, 22, 0, 0, 0, 0, 32'h31, 0, 0);        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("prerst_count", 32'(o_count), 32'd2);
        check("prerst_we", 32'(bus.rf_we), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_we", 32'(bus.rf_we), 32'd0);
        check("arst_count", 32'(o_count), 32'd0);
        check("arst_ready", 32'(bus.in_ready), 32'd1);
        #3 rst_n = 1'b1;
        bus.rf_gnt = 1'b1;
        tick();
        check("postrst_we", 32'(bus.rf_we), 32'd0);
        check("postrst_count", 32'(o_count), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
